// File: rtl/audio_mix_scheduler.sv
// Per-frame mixer: visits each enabled voice in order, sums one {L,R} sample per voice
// with saturation and writes a single stereo word into the live-audio FIFO.
module audio_mix_scheduler #(
  parameter int NUM_VOICES  = 4,
  parameter int AUDIO_WIDTH = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [NUM_VOICES*2*AUDIO_WIDTH-1:0] voice_data,
  input  logic [NUM_VOICES-1:0]               voice_valid,
  output logic [NUM_VOICES-1:0]               voice_ready,
  input  logic [NUM_VOICES-1:0]               voice_mask,
  output logic [2*AUDIO_WIDTH-1:0]            sample_data,
  output logic                                sample_en,
  input  logic                                sample_full,
  output logic [15:0]                         underrun_count
);

  localparam int ACC_W = AUDIO_WIDTH + $clog2(NUM_VOICES) + 1;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int WC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(TIMEOUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-AUDIO_WIDTH+1){1'b0}}, {(AUDIO_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-AUDIO_WIDTH+1){1'b1}}, {(AUDIO_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_GATHER, S_SAT, S_PUSH} state_t;

  state_t                   r_state, w_state_nxt;
  logic [IDX_W-1:0]         r_idx;
  logic [WC_W-1:0]          r_wait_cnt;
  logic [NUM_VOICES-1:0]    r_mask_q;
  logic signed [ACC_W-1:0]  r_acc_l, r_acc_r;
  logic [2*AUDIO_WIDTH-1:0] r_sample_data;
  logic [15:0]              r_underrun;

  logic                     w_start, w_take, w_timeout, w_advance, w_wait_inc;
  logic [2*AUDIO_WIDTH-1:0] w_voice;
  logic signed [ACC_W-1:0]  w_ext_l, w_ext_r;

  function automatic logic [AUDIO_WIDTH-1:0] f_clamp(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)      return SAT_MAX[AUDIO_WIDTH-1:0];
    else if (a < SAT_MIN) return SAT_MIN[AUDIO_WIDTH-1:0];
    else                  return a[AUDIO_WIDTH-1:0];
  endfunction

  assign w_voice = voice_data[int'(r_idx)*(2*AUDIO_WIDTH) +: 2*AUDIO_WIDTH];
  assign w_ext_l = {{(ACC_W-AUDIO_WIDTH){w_voice[2*AUDIO_WIDTH-1]}}, w_voice[2*AUDIO_WIDTH-1:AUDIO_WIDTH]};
  assign w_ext_r = {{(ACC_W-AUDIO_WIDTH){w_voice[AUDIO_WIDTH-1]}}, w_voice[AUDIO_WIDTH-1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // A valid sample on the expiry cycle is taken in preference to the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_take      = 1'b0;
    w_timeout   = 1'b0;
    w_advance   = 1'b0;
    w_wait_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!sample_full) begin
          w_start     = 1'b1;
          w_state_nxt = S_GATHER;
        end
      end
      S_GATHER: begin
        if (!r_mask_q[r_idx]) begin
          w_advance = 1'b1;
        end else if (voice_valid[r_idx]) begin
          w_take    = 1'b1;
          w_advance = 1'b1;
        end else if (r_wait_cnt == WC_LAST) begin
          w_timeout = 1'b1;
          w_advance = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
        if (w_advance && (r_idx == IDX_LAST)) w_state_nxt = S_SAT;
      end
      S_SAT:   w_state_nxt = S_PUSH;
      S_PUSH:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx         <= '0;
      r_wait_cnt    <= '0;
      r_mask_q      <= '0;
      r_acc_l       <= '0;
      r_acc_r       <= '0;
      r_sample_data <= '0;
      r_underrun    <= '0;
    end else begin
      if (w_start) begin
        r_mask_q   <= voice_mask;
        r_acc_l    <= '0;
        r_acc_r    <= '0;
        r_idx      <= '0;
        r_wait_cnt <= '0;
      end
      if (w_take) begin
        r_acc_l <= r_acc_l + w_ext_l;
        r_acc_r <= r_acc_r + w_ext_r;
      end
      if (w_advance) begin
        r_wait_cnt <= '0;
        if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
      end else if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_timeout && (r_underrun != 16'hFFFF)) r_underrun <= r_underrun + 16'd1;
      if (r_state == S_SAT) r_sample_data <= {f_clamp(r_acc_l), f_clamp(r_acc_r)};
    end
  end

  // Ready decodes from registers only, so it is one-hot or zero and drops with reset.
  always_comb begin
    voice_ready = '0;
    if ((r_state == S_GATHER) && r_mask_q[r_idx]) voice_ready[r_idx] = 1'b1;
  end

  assign sample_en      = (r_state == S_PUSH);
  assign sample_data    = r_sample_data;
  assign underrun_count = r_underrun;

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Bench for audio_mix_scheduler: directed frames plus randomized back-to-back frames,
// checked against a clamped-sum reference model.
module tb_audio_mix_scheduler;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic [N*2*AW-1:0] voice_data;
  logic [N-1:0]      voice_valid, voice_ready, voice_mask;
  logic [2*AW-1:0]   sample_data;
  logic              sample_en, sample_full;
  logic [15:0]       underrun_count;

  audio_mix_scheduler #(.NUM_VOICES(N), .AUDIO_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .voice_data(voice_data), .voice_valid(voice_valid),
    .voice_ready(voice_ready), .voice_mask(voice_mask), .sample_data(sample_data),
    .sample_en(sample_en), .sample_full(sample_full), .underrun_count(underrun_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { logic [31:0] d; int c; } push_t;
  typedef struct { logic [N-1:0] r; int c; } rdy_t;
  push_t push_q[$];
  rdy_t  rdy_log[$];
  int    rdy_cnt[N];

  always @(negedge clk) begin
    if (resetn) begin
      chk("ready_onehot", 64'($onehot0(voice_ready)), 64'd1);
      if (sample_en) push_q.push_back('{sample_data, cyc});
      if (voice_ready != '0) rdy_log.push_back('{voice_ready, cyc});
      for (int i = 0; i < N; i++) if (voice_ready[i]) rdy_cnt[i]++;
    end
  end

  int vl[N];
  int vr[N];

  function automatic int clamp16(input int s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic logic [31:0] mix(input logic [N-1:0] m, input logic [N-1:0] contrib);
    int sl, sr, cl, cr;
    sl = 0;
    sr = 0;
    for (int i = 0; i < N; i++)
      if (m[i] && contrib[i]) begin
        sl += vl[i];
        sr += vr[i];
      end
    cl = clamp16(sl);
    cr = clamp16(sr);
    return {cl[15:0], cr[15:0]};
  endfunction

  task automatic drive_voices();
    for (int i = 0; i < N; i++) begin
      int a, b;
      a = vl[i];
      b = vr[i];
      voice_data[i*32 +: 32] = {a[15:0], b[15:0]};
    end
  endtask

  task automatic clear_logs();
    push_q.delete();
    rdy_log.delete();
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
  endtask

  task automatic go_idle();
    sample_full = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    clear_logs();
  endtask

  task automatic start_frame(output int k0);
    @(posedge clk);
    #1;
    sample_full = 1'b0;
    k0 = cyc;
    @(posedge clk);
    #1;
    sample_full = 1'b1;
  endtask

  task automatic wait_push(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (push_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) chk("push_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int    k0, prev_c, got_n;
    bit    ok;
    push_t p;
    logic [31:0] exp_q[$];

    resetn      = 1'b0;
    sample_full = 1'b1;
    voice_valid = '0;
    voice_mask  = '0;
    voice_data  = '0;
    for (int i = 0; i < N; i++) begin vl[i] = 0; vr[i] = 0; end
    #2;
    chk("rst_ready", 64'(voice_ready), 64'd0);
    chk("rst_en", 64'(sample_en), 64'd0);
    chk("rst_data", 64'(sample_data), 64'd0);
    chk("rst_underrun", 64'(underrun_count), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    go_idle();

    // Two voices enabled; ordering and latency of a single frame.
    vl[0] = 1000; vr[0] = -200; vl[1] = 500; vr[1] = 300;
    vl[2] = 7;    vr[2] = 7;    vl[3] = 9;   vr[3] = 9;
    drive_voices();
    voice_mask  = 4'b0011;
    voice_valid = 4'b1111;
    start_frame(k0);
    wait_push(40, ok);
    chk("t2_ready_n", 64'(rdy_log.size()), 64'd2);
    if (rdy_log.size() >= 2) begin
      chk("t2_ready0", 64'(rdy_log[0].r), 64'b0001);
      chk("t2_ready0_cyc", 64'(rdy_log[0].c), 64'(k0 + 1));
      chk("t2_ready1", 64'(rdy_log[1].r), 64'b0010);
      chk("t2_ready1_cyc", 64'(rdy_log[1].c), 64'(k0 + 2));
    end
    if (ok) begin
      chk("t2_push_cyc", 64'(push_q[0].c), 64'(k0 + 6));
      chk("t2_data", 64'(push_q[0].d), 64'h05DC_0064);
    end
    go_idle();
    chk("t2_single_push", 64'(push_q.size()), 64'd0);

    // Saturation in both directions.
    for (int i = 0; i < N; i++) begin vl[i] = 30000; vr[i] = -30000; end
    drive_voices();
    voice_mask = 4'b1111;
    start_frame(k0);
    wait_push(40, ok);
    if (ok) chk("t3_sat", 64'(push_q[0].d), 64'h7FFF_8000);
    go_idle();

    // FIFO full holds the scheduler in idle.
    repeat (20) @(posedge clk);
    #1;
    chk("t4_no_ready", 64'(rdy_log.size()), 64'd0);
    chk("t4_no_push", 64'(push_q.size()), 64'd0);
    for (int i = 0; i < N; i++) begin
      vl[i] = int'($urandom_range(0, 20000)) - 10000;
      vr[i] = int'($urandom_range(0, 20000)) - 10000;
    end
    drive_voices();
    start_frame(k0);
    wait_push(40, ok);
    if (rdy_log.size() > 0) begin
      chk("t4_first_ready", 64'(rdy_log[0].r), 64'b0001);
      chk("t4_first_ready_cyc", 64'(rdy_log[0].c), 64'(k0 + 1));
    end else chk("t4_first_ready", 64'd0, 64'd1);
    if (ok) chk("t4_data", 64'(push_q[0].d), 64'(mix(4'b1111, 4'b1111)));
    go_idle();

    // Voice 2 stalls: timeout, then valid exactly on the last allowed cycle.
    voice_valid = 4'b1011;
    start_frame(k0);
    wait_push(80, ok);
    chk("t5_ready2_len", 64'(rdy_cnt[2]), 64'(TO));
    chk("t5_underrun", 64'(underrun_count), 64'd1);
    if (ok) chk("t5_data", 64'(push_q[0].d), 64'(mix(4'b1111, 4'b1011)));
    go_idle();
    start_frame(k0);
    got_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (voice_ready[2]) begin got_n = 1; break; end
    end
    chk("t5b_ready2_seen", 64'(got_n), 64'd1);
    repeat (TO - 1) @(posedge clk);
    #1;
    voice_valid[2] = 1'b1;
    wait_push(80, ok);
    chk("t5b_ready2_len", 64'(rdy_cnt[2]), 64'(TO));
    chk("t5b_underrun", 64'(underrun_count), 64'd1);
    if (ok) chk("t5b_data", 64'(push_q[0].d), 64'(mix(4'b1111, 4'b1111)));
    go_idle();

    // Reset in the middle of a frame while voice 1 is stalled.
    voice_valid = 4'b1101;
    start_frame(k0);
    got_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (voice_ready[1]) begin got_n = 1; break; end
    end
    chk("t1_ready1_seen", 64'(got_n), 64'd1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("t1_ready_drop", 64'(voice_ready), 64'd0);
    chk("t1_en_drop", 64'(sample_en), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_en_in_rst", 64'(sample_en), 64'd0);
    resetn = 1'b1;
    chk("t1_underrun_clr", 64'(underrun_count), 64'd0);
    chk("t1_no_push", 64'(push_q.size()), 64'd0);
    voice_valid = 4'b1111;
    clear_logs();
    start_frame(k0);
    wait_push(40, ok);
    if (ok) begin
      chk("t1_restart_cyc", 64'(push_q[0].c), 64'(k0 + 6));
      chk("t1_restart_data", 64'(push_q[0].d), 64'(mix(4'b1111, 4'b1111)));
    end
    go_idle();

    // 100 back-to-back random frames with random masks.
    for (int i = 0; i < N; i++) begin
      vl[i] = int'($urandom_range(0, 65535)) - 32768;
      vr[i] = int'($urandom_range(0, 65535)) - 32768;
    end
    drive_voices();
    voice_mask = 4'($urandom_range(0, 15));
    exp_q.push_back(mix(voice_mask, 4'b1111));
    @(posedge clk);
    #1;
    sample_full = 1'b0;
    prev_c = 0;
    got_n  = 0;
    for (int f = 0; f < 100; f++) begin
      wait_push(30, ok);
      if (!ok) break;
      p = push_q.pop_front();
      got_n++;
      chk("t6_data", 64'(p.d), 64'(exp_q.pop_front()));
      if (f > 0) chk("t6_period", 64'(p.c - prev_c), 64'(N + 3));
      prev_c = p.c;
      if (f < 99) begin
        for (int i = 0; i < N; i++) begin
          vl[i] = int'($urandom_range(0, 65535)) - 32768;
          vr[i] = int'($urandom_range(0, 65535)) - 32768;
        end
        drive_voices();
        voice_mask = 4'($urandom_range(0, 15));
        exp_q.push_back(mix(voice_mask, 4'b1111));
      end else begin
        sample_full = 1'b1;
      end
    end
    repeat (20) @(posedge clk);
    #1;
    chk("t6_strobes", 64'(got_n + push_q.size()), 64'd100);
    chk("t6_underrun", 64'(underrun_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
